// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - execute stage: single-cycle ALU, LOAD/STORE address add, 16-step shift-add MUL
module execute_stage #(
  parameter logic [3:0] LOAD  = 4'b1100,
  parameter logic [3:0] STORE = 4'b1110,
  parameter logic [3:0] NOP   = 4'b1111,
  parameter logic [3:0] MUL   = 4'b1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  control_id,
  input  logic [15:0] operand_a_id,
  input  logic [15:0] operand_b_id,
  input  logic [15:0] store_data_id,
  input  logic [4:0]  dest_reg_index_id,
  input  logic        dest_reg_write_en_id,
  input  logic        flush_id,
  output logic [3:0]  control_ex,
  output logic [15:0] result_ex,
  output logic [15:0] reg_data_ex,
  output logic [4:0]  dest_reg_index_ex,
  output logic        dest_reg_write_en_ex,
  output logic [2:0]  flags_ex,
  output logic        stall_ex
);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t      state;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [15:0] acc;
  logic [3:0]  count;
  logic [4:0]  mul_dest;
  logic        mul_we;

  logic [15:0] alu_res;
  logic        alu_carry;
  logic [16:0] sum17;
  logic [15:0] step_acc;

  assign sum17 = {1'b0, operand_a_id} + {1'b0, operand_b_id};

  always_comb begin
    alu_res   = 16'h0000;
    alu_carry = 1'b0;
    case (control_id)
      4'b0000: begin alu_res = sum17[15:0]; alu_carry = sum17[16]; end
      4'b0001: begin alu_res = operand_a_id - operand_b_id; alu_carry = operand_a_id < operand_b_id; end
      4'b0010: alu_res = operand_a_id & operand_b_id;
      4'b0011: alu_res = operand_a_id | operand_b_id;
      4'b0100: alu_res = operand_a_id ^ operand_b_id;
      4'b0101: alu_res = ~operand_a_id;
      4'b0110: alu_res = operand_a_id << operand_b_id[3:0];
      4'b0111: alu_res = operand_a_id >> operand_b_id[3:0];
      default: alu_res = 16'h0000;
    endcase
  end

  // One shift-add step; on the last count this is the final product.
  assign step_acc = acc + (mplier[count] ? (mcand << count) : 16'h0000);

  assign stall_ex = !reset && !flush_id &&
                    (((state == IDLE) && (control_id == MUL)) ||
                     ((state == MUL_BUSY) && (count != 4'd15)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      count                <= 4'd0;
      acc                  <= 16'h0000;
      mcand                <= 16'h0000;
      mplier               <= 16'h0000;
      mul_dest             <= 5'd0;
      mul_we               <= 1'b0;
      control_ex           <= NOP;
      result_ex            <= 16'h0000;
      reg_data_ex          <= 16'h0000;
      dest_reg_index_ex    <= 5'd0;
      dest_reg_write_en_ex <= 1'b0;
      flags_ex             <= 3'b000;
    end else if (flush_id) begin
      state                <= IDLE;
      count                <= 4'd0;
      control_ex           <= NOP;
      dest_reg_write_en_ex <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (control_id == MUL) begin
            mcand                <= operand_a_id;
            mplier               <= operand_b_id;
            acc                  <= 16'h0000;
            count                <= 4'd0;
            mul_dest             <= dest_reg_index_id;
            mul_we               <= dest_reg_write_en_id;
            state                <= MUL_BUSY;
            control_ex           <= NOP;
            dest_reg_write_en_ex <= 1'b0;
          end else if (control_id[3] == 1'b0) begin
            control_ex           <= control_id;
            result_ex            <= alu_res;
            flags_ex             <= {alu_carry, alu_res[15], alu_res == 16'h0000};
            dest_reg_index_ex    <= dest_reg_index_id;
            dest_reg_write_en_ex <= dest_reg_write_en_id;
          end else if ((control_id == LOAD) || (control_id == STORE)) begin
            control_ex           <= control_id;
            result_ex            <= sum17[15:0];
            reg_data_ex          <= store_data_id;
            dest_reg_index_ex    <= dest_reg_index_id;
            dest_reg_write_en_ex <= dest_reg_write_en_id;
          end else begin
            control_ex           <= NOP;
            dest_reg_write_en_ex <= 1'b0;
          end
        end
        MUL_BUSY: begin
          acc   <= step_acc;
          count <= count + 4'd1;
          if (count == 4'd15) begin
            state                <= IDLE;
            count                <= 4'd0;
            control_ex           <= MUL;
            result_ex            <= step_acc;
            flags_ex             <= {1'b0, step_acc[15], step_acc == 16'h0000};
            dest_reg_index_ex    <= mul_dest;
            dest_reg_write_en_ex <= mul_we;
          end else begin
            control_ex           <= NOP;
            dest_reg_write_en_ex <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameters: LOAD = 4'b1100, load opcode; STORE = 4'b1110, store opcode; NOP = 4'b1111, bubble opcode; MUL = 4'b1000, multi-cycle multiply opcode.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 control_id  input  4  opcode of the incoming instruction.
REQ-005 operand_a_id, operand_b_id  input  16 each  source operands.
REQ-006 store_data_id  input  16  register data to be stored by STORE.
REQ-007 dest_reg_index_id  input  5  destination register index.
REQ-008 dest_reg_write_en_id  input  1  destination write enable.
REQ-009 flush_id  input  1  kill the current instruction, including any in-flight MUL.
REQ-010 control_ex  output  4  registered opcode to memory stage.
REQ-011 result_ex  output  16  registered ALU result or memory address.
REQ-012 reg_data_ex  output  16  registered store data.
REQ-013 dest_reg_index_ex  output  5  registered destination index.
REQ-014 dest_reg_write_en_ex  output  1  registered destination write enable.
REQ-015 flags_ex  output  3  registered {carry, negative, zero}.
REQ-016 stall_ex  output  1  combinational; while high, upstream SHALL hold all *_id inputs stable.

Function
REQ-017 Opcodes: 0000 ADD, 0001 SUB (a-b), 0010 AND, 0011 OR, 0100 XOR, 0101 NOT a, 0110 SHL (a << b[3:0]), 0111 SHR logical (a >> b[3:0]), 1000 MUL, 1100 LOAD, 1110 STORE, 1111 NOP; all other codes are treated as NOP.
REQ-018 Single-cycle ops: all outputs register the op result on the edge after presentation, giving a latency of 1 cycle.
REQ-019 LOAD and STORE: result_ex = a+b (mod 2^16); reg_data_ex = store_data_id.
REQ-020 NOP: control_ex=NOP and dest_reg_write_en_ex=0; result_ex, reg_data_ex and flags_ex hold their previous values.
REQ-021 Carry: ADD gives the carry-out of the 17-bit sum; SUB gives borrow (1 when a<b unsigned).
REQ-022 Zero and negative: zero = result==0 and negative = result[15], updated for ADD/SUB/AND/OR/XOR/NOT/SHL/SHR/MUL; for LOGIC/SHIFT/MUL ops carry is cleared; LOAD/STORE/NOP hold all flags.
REQ-023 FSM has two states: IDLE and MUL_BUSY.
REQ-024 IDLE with control_id==MUL and flush_id=0:
  - latch a and b, clear the accumulator, set the 4-bit counter to 0;
  - go to MUL_BUSY;
  - stall_ex=1;
  - outputs register a bubble (control_ex=NOP, write_en=0).
REQ-025 MUL_BUSY, each cycle, one shift-add step:
  - if multiplier bit[count] is set, acc += multiplicand << count, truncated to 16 bits;
  - count increments;
  - outputs register a bubble;
  - stall_ex=1 while count<15.
REQ-026 MUL_BUSY with count==15:
  - stall_ex=0;
  - the final step is folded in and registered to outputs with control_ex=MUL, the latched destination index/enable, and flags per REQ-022;
  - FSM returns to IDLE.
REQ-027 MUL total: 17 cycles from first presentation to result on outputs; stall_ex is high for exactly 16 consecutive cycles; the result is the low 16 bits of the product.
REQ-028 flush_id=1 in any state: the next edge registers a bubble, FSM goes to IDLE, the counter clears, and stall_ex=0 in that cycle; flush takes priority over starting or completing a MUL.
REQ-029 MUL_BUSY ignores changes on *_id inputs; only values latched at acceptance are used.
REQ-030 Back-to-back MULs: a new MUL presented in the cycle after completion is accepted normally, with no lost or duplicated result.

Reset
REQ-031 reset=1 at an edge:
  - control_ex=NOP;
  - result_ex, reg_data_ex and flags_ex = 0;
  - dest_reg_index_ex=0 and dest_reg_write_en_ex=0;
  - FSM=IDLE and counter=0.
REQ-032 Reset takes priority over flush and over in-flight MUL; stall_ex=0 during reset.

Verification
REQ-033 ADD a=16'hFFFF, b=16'h0001, dest 3, write_en 1 -> next cycle result_ex=0000, flags_ex=3'b101, control_ex=0000, dest_reg_index_ex=3.
REQ-034 STORE a=16'h0010, b=16'h0005, store_data=16'hBEEF -> next cycle control_ex=1110, result_ex=0015, reg_data_ex=BEEF, flags unchanged.
REQ-035 MUL a=16'h0123, b=16'h0045 held stable -> stall_ex high 16 cycles, 16 bubbles on outputs, then result_ex=16'h4E6F, control_ex=1000.
REQ-036 MUL in flight; flush_id=1 at cycle 8 of MUL_BUSY -> next cycle bubble, stall_ex=0, FSM IDLE; no MUL result is ever emitted.
REQ-037 reset asserted mid-MUL (count=5) -> all outputs at reset values, stall_ex=0; a subsequent SUB a=3, b=5 gives result_ex=FFFE, flags_ex=3'b110.
REQ-038 Two back-to-back MULs (2x3, then 4x5) -> results 0006 and 0014 appear 17 cycles apart, each exactly once.
